// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte stream in (in_data/in_valid/in_ready) and instruction-memory write port out
// slave  : loader side, consumes the stream and drives the write port
// master : source/memory side, drives the stream and observes the write port
interface imem_boot_loader_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  modport slave (input in_data, in_valid, output in_ready, imem_we, imem_addr, imem_wdata);
  modport master (output in_data, in_valid, input in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: assembles a length-prefixed, XOR-checksummed byte stream into 32-bit words written to imem
// clk, rst     : clock, synchronous active-high reset
// start        : begins a load when idle, done or failed
// bus          : stream in (in_data/in_valid/in_ready), write out (imem_we/imem_addr/imem_wdata)
// cpu_rst      : core reset, released only after a verified load
// busy/done/error, words_loaded : load status
module imem_boot_loader #(
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  imem_boot_loader_if.slave bus,
  output logic cpu_rst,
  output logic busy,
  output logic done,
  output logic error,
  output logic [15:0] words_loaded
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERROR} state_t;
  state_t state, state_n;
  logic [15:0] len, len_n, wl_n, n;
  logic [1:0] cnt, cnt_n;
  logic [23:0] sh, sh_n;
  logic [7:0] csum, csum_n;
  logic [31:0] addr_n, wdata_n;
  logic acc, we_n, ready_n, cpu_rst_n, busy_n, done_n, error_n;
  assign acc = bus.in_valid && bus.in_ready;
  assign n = {len[15:8], bus.in_data};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len <= '0;
      cnt <= '0;
      sh <= '0;
      csum <= '0;
      words_loaded <= '0;
      bus.in_ready <= 1'b0;
      bus.imem_we <= 1'b0;
      bus.imem_addr <= '0;
      bus.imem_wdata <= '0;
      cpu_rst <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      len <= len_n;
      cnt <= cnt_n;
      sh <= sh_n;
      csum <= csum_n;
      words_loaded <= wl_n;
      bus.in_ready <= ready_n;
      bus.imem_we <= we_n;
      bus.imem_addr <= addr_n;
      bus.imem_wdata <= wdata_n;
      cpu_rst <= cpu_rst_n;
      busy <= busy_n;
      done <= done_n;
      error <= error_n;
    end
  end
  always_comb begin
    state_n = state;
    len_n = len;
    cnt_n = cnt;
    sh_n = sh;
    csum_n = csum;
    wl_n = words_loaded;
    we_n = 1'b0;
    addr_n = bus.imem_addr;
    wdata_n = bus.imem_wdata;
    cpu_rst_n = cpu_rst;
    busy_n = busy;
    done_n = done;
    error_n = error;
    case (state)
      IDLE, DONE, ERROR: if (start) begin
        state_n = LEN_HI;
        cnt_n = '0;
        csum_n = '0;
        wl_n = '0;
        cpu_rst_n = 1'b1;
        busy_n = 1'b1;
        done_n = 1'b0;
        error_n = 1'b0;
      end
      LEN_HI: if (acc) begin
        len_n = {bus.in_data, 8'h00};
        state_n = LEN_LO;
      end
      LEN_LO: if (acc) begin
        len_n = n;
        state_n = ({16'h0, n} > MAX_WORDS) ? ERROR : (n == '0) ? CHK : DATA;
        busy_n = ({16'h0, n} <= MAX_WORDS);
        error_n = ({16'h0, n} > MAX_WORDS);
      end
      DATA: if (acc) begin
        csum_n = csum ^ bus.in_data;
        cnt_n = cnt + 2'd1;
        sh_n = {sh[15:0], bus.in_data};
        if (cnt == 2'd3) begin
          we_n = 1'b1;
          wdata_n = {sh, bus.in_data};
          addr_n = BASE_ADDR + {14'h0, words_loaded, 2'b00};
          wl_n = words_loaded + 16'd1;
          state_n = (wl_n == len) ? CHK : DATA;
        end
      end
      CHK: if (acc) begin
        state_n = (bus.in_data == csum) ? DONE : ERROR;
        busy_n = 1'b0;
        done_n = (bus.in_data == csum);
        error_n = (bus.in_data != csum);
        cpu_rst_n = (bus.in_data != csum);
      end
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == LEN_HI) || (state_n == LEN_LO) || (state_n == DATA) || (state_n == CHK);
  end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream companion of the single-cycle processor core.
- Receives a byte stream over a valid/ready interface and assembles it into 32-bit instruction words.
- Writes those words into instruction memory at sequential byte addresses.
- Holds the core in reset until a complete, checksum-verified program image has been written.

Parameters:
- MAX_WORDS, 256: largest program length accepted, in words.
- BASE_ADDR, 32'h0000_0000: byte address of the first instruction word written.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  32  byte address of the write (BASE_ADDR + 4*index).
- imem_wdata  output  32  instruction word to write.
- cpu_rst  output  1  reset to the processor core; high while loading or failed.
- busy  output  1  a load is in progress.
- done  output  1  last load succeeded.
- error  output  1  last load failed (bad length or checksum).
- words_loaded  output  16  words written in the current or last load.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high, sampled on the rising edge. All state is registered.
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, busy=0, done=0, error=0, words_loaded=0. The byte counter, assembly register and checksum accumulator are cleared.
- Handshake: a byte is accepted on a cycle with in_valid&&in_ready. in_ready is registered and is high only in LEN_HI, LEN_LO, DATA and CHK. in_valid may drop at any time without loss.
- Stream format: LEN_HI, LEN_LO (big-endian 16-bit word count N), then 4*N data bytes, then one checksum byte equal to the XOR of all data bytes.
- State transitions:
  - IDLE/DONE/ERROR + start -> LEN_HI. This clears done, error, words_loaded and the checksum, sets busy=1 and cpu_rst=1.
  - LEN_HI -> LEN_LO on accept.
  - LEN_LO on accept: if N > MAX_WORDS -> ERROR; if N == 0 -> CHK; otherwise -> DATA.
  - DATA: each accepted byte is XORed into the checksum and shifted in big-endian (first byte -> [31:24]). On the 4th byte of a word, in the next cycle: imem_we=1 for exactly one cycle, imem_wdata = assembled word, imem_addr = BASE_ADDR + 4*words_loaded (pre-increment), and words_loaded increments. After word N the state moves to CHK. in_ready stays high during the write cycle; there are no bubbles.
  - CHK on accept: byte == checksum -> DONE; otherwise -> ERROR.
  - DONE: busy=0, done=1, cpu_rst=0 from the cycle after the checksum byte is accepted.
  - ERROR: busy=0, error=1, cpu_rst=1, in_ready=0. Words already written are not rolled back.
- start while busy is ignored.
- rst mid-load returns every output to its reset value on the next edge; a partially assembled word is discarded and never written.
- Address arithmetic is 32-bit and wraps modulo 2^32. words_loaded never exceeds MAX_WORDS.
- imem_addr and imem_wdata hold their last value when imem_we=0.

Test Plan:
- Nominal load: rst, start, then stream 00 02 12 34 56 78 9A BC DE F0 00 with continuous valid -> imem_we pulses twice: 0x12345678 @0x0, then 0x9ABCDEF0 @0x4; done=1, error=0, cpu_rst=0, words_loaded=2.
- Bad checksum: same stream with final byte FF -> both writes still occur; error=1, done=0, cpu_rst=1, in_ready=0.
- Oversize length: stream 01 01 with MAX_WORDS=256 -> ERROR right after LEN_LO; zero imem_we pulses; in_ready=0.
- Backpressure gaps: nominal stream with in_valid low for 1-3 random cycles between bytes -> identical writes and final flags to the nominal case.
- Reset mid-load: after 00 02 12 34 56, assert rst for one cycle -> all outputs at reset values, no write issued. Then start and nominal stream -> writes start again at 0x0.
- Empty program and reload: stream 00 00 00 -> done=1, no writes. Then start in DONE -> cpu_rst=1, busy=1, done=0 in the following cycle.
